// File: rtl/clock_pkg.sv
// Shared types, BCD limits and step helpers for the clock time-set controller.
package clock_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        SET_HH = 2'd1,
        SET_MM = 2'd2
    } state_t;

    localparam logic [7:0] HH_MIN = 8'h01;
    localparam logic [7:0] HH_MAX = 8'h12;
    localparam logic [7:0] MM_MAX = 8'h59;

    typedef struct packed {
        logic [7:0] hh;
        logic       pm_tgl;
    } hh_step_t;

    // 11 -> 12 is where the AM/PM flag flips; 12 -> 01 keeps it.
    function automatic hh_step_t bcd_inc_hh(input logic [7:0] hh);
        hh_step_t r;
        r.pm_tgl = 1'b0;
        if (hh == HH_MAX) begin
            r.hh = HH_MIN;
        end else if (hh == 8'h11) begin
            r.hh     = HH_MAX;
            r.pm_tgl = 1'b1;
        end else if (hh[3:0] == 4'd9) begin
            r.hh = {hh[7:4] + 4'd1, 4'd0};
        end else begin
            r.hh = {hh[7:4], hh[3:0] + 4'd1};
        end
        return r;
    endfunction

    function automatic logic [7:0] bcd_inc_mm(input logic [7:0] mm);
        if (mm == MM_MAX) begin
            return 8'h00;
        end else if (mm[3:0] == 4'd9) begin
            return {mm[7:4] + 4'd1, 4'd0};
        end else begin
            return {mm[7:4], mm[3:0] + 4'd1};
        end
    endfunction

endpackage

// File: rtl/clock_set_ctrl_if.sv
// Bundle between the controller, the debounced buttons and clock_main.
interface clock_set_ctrl_if;

    logic       btn_mode;
    logic       btn_inc;
    logic [7:0] cur_hh;
    logic [7:0] cur_mm;
    logic       cur_pm;
    logic       ena;
    logic       load;
    logic [7:0] load_hh;
    logic [7:0] load_mm;
    logic       load_pm;
    logic       setting;
    logic [1:0] blank;

    modport slave (
        input  btn_mode, btn_inc, cur_hh, cur_mm, cur_pm,
        output ena, load, load_hh, load_mm, load_pm, setting, blank
    );

    modport master (
        output btn_mode, btn_inc, cur_hh, cur_mm, cur_pm,
        input  ena, load, load_hh, load_mm, load_pm, setting, blank
    );

endinterface

// File: rtl/clock_tick_gen.sv
// Free-running prescaler: one-cycle ena on wrap, blink during the first half of each period.
module clock_tick_gen #(
    parameter int unsigned TICK_DIV = 100_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    output logic ena_o,
    output logic blink_o
);

    localparam int unsigned CW = $clog2(TICK_DIV);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          ena_q, ena_d;

    // A clear also swallows a coincident wrap so the restart is a full period.
    always_comb begin
        cnt_d = cnt_q + CW'(1);
        ena_d = 1'b0;
        if (clr_i) begin
            cnt_d = '0;
        end else if (cnt_q == CW'(TICK_DIV - 1)) begin
            cnt_d = '0;
            ena_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            ena_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ena_q <= ena_d;
        end
    end

    assign ena_o   = ena_q;
    assign blink_o = (cnt_q < CW'(TICK_DIV / 2));

endmodule

// File: rtl/clock_set_ctrl.sv
// Two-button time-set sequencer and 1 Hz tick source for clock_main.
// Optional build macro CLOCK_SET_AUTOREPEAT_EN adds hold-to-repeat on btn_inc.
module clock_set_ctrl
    import clock_pkg::*;
#(
    parameter int unsigned TICK_DIV = 100_000_000
`ifdef CLOCK_SET_AUTOREPEAT_EN
    ,
    parameter int unsigned REPEAT_DLY = 50_000_000,
    parameter int unsigned REPEAT_PER = 20_000_000
`endif
) (
    input logic             clk,
    input logic             reset,
    clock_set_ctrl_if.slave bus
);

    state_t     state_q, state_d;
    logic       mode_q, inc_q;
    logic [7:0] hh_q, hh_d, mm_q, mm_d;
    logic       pm_q, pm_d;
    logic       load_q, load_d;
    logic       setting_q;
    logic       clr, tick_ena, blink;
    logic       mode_rise, inc_rise, step;
    hh_step_t   hh_nxt;

    assign mode_rise = bus.btn_mode & ~mode_q;
    assign inc_rise  = bus.btn_inc & ~inc_q;

`ifdef CLOCK_SET_AUTOREPEAT_EN
    // Zero means disarmed; re-arming needs a fresh edge. Assumes REPEAT_DLY >= REPEAT_PER.
    localparam int unsigned RW = $clog2(REPEAT_DLY + 1);
    logic [RW-1:0] rpt_q, rpt_d;
    logic          rpt_fire;

    assign rpt_fire = bus.btn_inc && (rpt_q == RW'(REPEAT_DLY));
    assign step     = inc_rise | rpt_fire;

    always_comb begin
        rpt_d = '0;
        if (state_q != RUN && !mode_rise && bus.btn_inc) begin
            if (inc_rise) begin
                rpt_d = RW'(1);
            end else if (rpt_fire) begin
                rpt_d = RW'(REPEAT_DLY - REPEAT_PER + 1);
            end else if (rpt_q != '0) begin
                rpt_d = rpt_q + RW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rpt_q <= '0;
        else        rpt_q <= rpt_d;
    end
`else
    assign step = inc_rise;
`endif

    always_comb begin
        state_d = state_q;
        hh_d    = hh_q;
        mm_d    = mm_q;
        pm_d    = pm_q;
        load_d  = 1'b0;
        clr     = 1'b0;
        hh_nxt  = bcd_inc_hh(hh_q);
        case (state_q)
            RUN: begin
                if (mode_rise) begin
                    state_d = SET_HH;
                    hh_d    = bus.cur_hh;
                    mm_d    = bus.cur_mm;
                    pm_d    = bus.cur_pm;
                end
            end
            SET_HH: begin
                if (mode_rise) begin
                    state_d = SET_MM;
                end else if (step) begin
                    hh_d = hh_nxt.hh;
                    pm_d = pm_q ^ hh_nxt.pm_tgl;
                end
            end
            SET_MM: begin
                if (mode_rise) begin
                    state_d = RUN;
                    load_d  = 1'b1;
                    clr     = 1'b1;
                end else if (step) begin
                    mm_d = bcd_inc_mm(mm_q);
                end
            end
            default: state_d = RUN;
        endcase
    end

    // Edge detectors reset high so a button held through reset release is not an edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= RUN;
            mode_q    <= 1'b1;
            inc_q     <= 1'b1;
            hh_q      <= HH_MAX;
            mm_q      <= 8'h00;
            pm_q      <= 1'b0;
            load_q    <= 1'b0;
            setting_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= bus.btn_mode;
            inc_q     <= bus.btn_inc;
            hh_q      <= hh_d;
            mm_q      <= mm_d;
            pm_q      <= pm_d;
            load_q    <= load_d;
            setting_q <= (state_d != RUN);
        end
    end

    clock_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .clk    (clk),
        .reset  (reset),
        .clr_i  (clr),
        .ena_o  (tick_ena),
        .blink_o(blink)
    );

    assign bus.ena     = tick_ena & (state_q == RUN);
    assign bus.load    = load_q;
    assign bus.load_hh = hh_q;
    assign bus.load_mm = mm_q;
    assign bus.load_pm = pm_q;
    assign bus.setting = setting_q;
    assign bus.blank   = {(state_q == SET_HH) & ~blink, (state_q == SET_MM) & ~blink};

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Randomized and directed bench for clock_set_ctrl against a time-of-day reference model.
module tb_clock_set_ctrl;

    localparam int TD = 10;
`ifdef CLOCK_SET_AUTOREPEAT_EN
    localparam int RD = 20;
    localparam int RP = 5;
`endif

    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;

    clock_set_ctrl_if bus();

    clock_set_ctrl #(
        .TICK_DIV(TD)
`ifdef CLOCK_SET_AUTOREPEAT_EN
        , .REPEAT_DLY(RD), .REPEAT_PER(RP)
`endif
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference model: plain integers for time, n = cycles since reset release or load.
    int   st, mh, mmin, n, rk;
    logic mpm, mld, mprev, iprev;
    int   cur_h, cur_m;
    logic cur_p;

    function automatic logic [7:0] to_bcd(input int v);
        return 8'((v / 10) * 16 + (v % 10));
    endfunction

    function automatic logic [21:0] exp_vec();
        logic e, off;
        e   = (st == 0) && (n > 0) && (n % TD == 0);
        off = (n % TD) >= (TD / 2);
        return {e, mld, to_bcd(mh), to_bcd(mmin), mpm, logic'(st != 0),
                logic'(st == 1 && off), logic'(st == 2 && off)};
    endfunction

    task automatic model_reset();
        st = 0; mh = 12; mmin = 0; mpm = 1'b0; mld = 1'b0;
        n = 0; rk = -1; mprev = 1'b1; iprev = 1'b1;
    endtask

    task automatic set_cur(input int h, input int m, input logic p);
        cur_h = h; cur_m = m; cur_p = p;
        bus.cur_hh = to_bcd(h);
        bus.cur_mm = to_bcd(m);
        bus.cur_pm = p;
    endtask

    task automatic cyc(input logic m, input logic i);
        logic mr, ir, stp;
        int   old;
        bus.btn_mode = m;
        bus.btn_inc  = i;
        @(posedge clk);
        #1;
        mr = m & ~mprev;
        ir = i & ~iprev;
        mprev = m; iprev = i;
        old = st; stp = 1'b0; mld = 1'b0;
        if (mr) begin
            if (st == 0) begin
                st = 1; mh = cur_h; mmin = cur_m; mpm = cur_p;
            end else if (st == 1) begin
                st = 2;
            end else begin
                st = 0; mld = 1'b1;
            end
        end else if (ir && st != 0) begin
            stp = 1'b1;
        end
`ifdef CLOCK_SET_AUTOREPEAT_EN
        if (st != old || !i) rk = -1;
        else if (ir && st != 0) rk = 0;
        else if (rk >= 0) begin
            rk++;
            if (rk >= RD && (rk - RD) % RP == 0) stp = 1'b1;
        end
`endif
        if (stp) begin
            if (st == 1) begin
                mh = mh % 12 + 1;
                if (mh == 12) mpm = ~mpm;
            end else begin
                mmin = (mmin + 1) % 60;
            end
        end
        n = mld ? 0 : n + 1;
    endtask

    task automatic do_reset();
        bus.btn_mode = 1'b0;
        bus.btn_inc  = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        cyc(0, 0);
        cyc(0, 0);
    endtask

    task automatic press_mode();
        cyc(1, 0);
        cyc(0, 0);
    endtask

    task automatic press_inc();
        cyc(0, 1);
        cyc(0, 0);
    endtask

    task automatic test_reset();
        logic [21:0] act;
        bus.btn_mode = 1'b1;
        bus.btn_inc  = 1'b1;
        @(posedge clk);
        #1;
        act = {bus.ena, bus.load, bus.load_hh, bus.load_mm, bus.load_pm, bus.setting, bus.blank};
        tests++;
        if (act !== {1'b0, 1'b0, 8'h12, 8'h00, 1'b0, 1'b0, 2'b00}) begin
            fails++;
            $display("FAIL reset_values: got %h want %h", act, {1'b0, 1'b0, 8'h12, 8'h00, 1'b0, 1'b0, 2'b00});
        end
        model_reset();
        reset = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            cyc(k < 3, k < 3);
            tests++;
            if (bus.ena !== logic'(k % 10 == 0) || bus.load !== 1'b0 || bus.setting !== 1'b0) begin
                fails++;
                $display("FAIL idle_tick k=%0d: ena=%b load=%b setting=%b want ena=%b load=0 setting=0",
                         k, bus.ena, bus.load, bus.setting, logic'(k % 10 == 0));
            end
        end
    endtask

    task automatic test_set_sequence();
        logic [4:0] is_inc;
        is_inc = 5'b11010;
        do_reset();
        set_cur(11, 58, 1'b0);
        for (int e = 0; e < 5; e++) begin
            for (int c = 0; c < 4; c++) begin
                cyc(c == 0 && !is_inc[e], c == 0 && is_inc[e]);
                tests++;
                if (bus.ena !== 1'b0 || bus.load !== 1'b0 || bus.setting !== 1'b1) begin
                    fails++;
                    $display("FAIL set_seq e=%0d c=%0d: ena=%b load=%b setting=%b want 0 0 1",
                             e, c, bus.ena, bus.load, bus.setting);
                end
            end
        end
        cyc(1, 0);
        tests++;
        if ({bus.load, bus.ena, bus.load_hh, bus.load_mm, bus.load_pm} !== {1'b1, 1'b0, 8'h12, 8'h00, 1'b1}) begin
            fails++;
            $display("FAIL set_seq_load: load=%b ena=%b hh=%h mm=%h pm=%b want 1 0 12 00 1",
                     bus.load, bus.ena, bus.load_hh, bus.load_mm, bus.load_pm);
        end
        for (int k = 1; k <= 12; k++) begin
            cyc(0, 0);
            tests++;
            if (bus.load !== 1'b0 || bus.ena !== logic'(k == 10)) begin
                fails++;
                $display("FAIL post_load_ena k=%0d: load=%b ena=%b want load=0 ena=%b",
                         k, bus.load, bus.ena, logic'(k == 10));
            end
        end
    endtask

    task automatic test_hour_wrap();
        int          hs[3];
        logic        ps[3];
        logic [7:0]  eh[3];
        logic        ep[3];
        hs = '{12, 9, 11};
        ps = '{1'b1, 1'b0, 1'b1};
        eh = '{8'h01, 8'h10, 8'h12};
        ep = '{1'b1, 1'b0, 1'b0};
        for (int t = 0; t < 3; t++) begin
            do_reset();
            set_cur(hs[t], 30, ps[t]);
            press_mode();
            press_inc();
            tests++;
            if (bus.load_hh !== eh[t] || bus.load_pm !== ep[t]) begin
                fails++;
                $display("FAIL hour_step from %0d: hh=%h pm=%b want hh=%h pm=%b",
                         hs[t], bus.load_hh, bus.load_pm, eh[t], ep[t]);
            end
        end
    endtask

    task automatic test_simultaneous();
        logic seen0;
        do_reset();
        set_cur(5, 20, 1'b0);
        press_mode();
        cyc(1, 1);
        tests++;
        if (bus.load_hh !== 8'h05 || bus.setting !== 1'b1) begin
            fails++;
            $display("FAIL simul_hours: hh=%h setting=%b want 05 1", bus.load_hh, bus.setting);
        end
        cyc(0, 0);
        seen0 = 1'b0;
        for (int k = 0; k < TD; k++) begin
            cyc(0, 0);
            seen0 |= bus.blank[0];
            tests++;
            if (bus.blank[1] !== 1'b0) begin
                fails++;
                $display("FAIL simul_blank_hh k=%0d: blank=%b want hours unblanked", k, bus.blank);
            end
        end
        tests++;
        if (seen0 !== 1'b1) begin
            fails++;
            $display("FAIL simul_blank_mm: minutes blank never seen, got %b want 1", seen0);
        end
        cyc(1, 0);
        tests++;
        if (bus.load !== 1'b1 || bus.load_hh !== 8'h05 || bus.load_mm !== 8'h20) begin
            fails++;
            $display("FAIL simul_load: load=%b hh=%h mm=%h want 1 05 20", bus.load, bus.load_hh, bus.load_mm);
        end
    endtask

    task automatic test_reset_mid_set();
        logic [21:0] act;
        do_reset();
        set_cur(7, 45, 1'b1);
        press_mode();
        press_mode();
        press_inc();
        tests++;
        if (bus.load_mm !== 8'h46 || bus.setting !== 1'b1) begin
            fails++;
            $display("FAIL midset_step: mm=%h setting=%b want 46 1", bus.load_mm, bus.setting);
        end
        #2 reset = 1'b0;
        #1;
        act = {bus.ena, bus.load, bus.load_hh, bus.load_mm, bus.load_pm, bus.setting, bus.blank};
        tests++;
        if (act !== {1'b0, 1'b0, 8'h12, 8'h00, 1'b0, 1'b0, 2'b00}) begin
            fails++;
            $display("FAIL midset_async: got %h want %h", act, {1'b0, 1'b0, 8'h12, 8'h00, 1'b0, 1'b0, 2'b00});
        end
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            cyc(0, 0);
            tests++;
            if (bus.load !== 1'b0 || bus.setting !== 1'b0 || bus.ena !== logic'(k == 10)) begin
                fails++;
                $display("FAIL midset_after k=%0d: load=%b setting=%b ena=%b want 0 0 %b",
                         k, bus.load, bus.setting, bus.ena, logic'(k == 10));
            end
        end
    endtask

    task automatic test_inc_hold();
        logic [7:0] want;
        do_reset();
        set_cur(3, 57, 1'b0);
        press_mode();
        press_mode();
        for (int k = 0; k < 36; k++) begin
            cyc(0, k < 35);
`ifdef CLOCK_SET_AUTOREPEAT_EN
            want = (k < 20) ? 8'h58 : (k < 25) ? 8'h59 : (k < 30) ? 8'h00 : 8'h01;
`else
            want = 8'h58;
`endif
            tests++;
            if (bus.load_mm !== want) begin
                fails++;
                $display("FAIL inc_hold k=%0d: mm=%h want %h", k, bus.load_mm, want);
            end
        end
    endtask

    task automatic test_random();
        logic        m, i;
        logic [21:0] act, expv;
        m = 1'b0;
        i = 1'b0;
        do_reset();
        set_cur($urandom_range(1, 12), $urandom_range(0, 59), 1'($urandom_range(0, 1)));
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 7) == 0) m = ~m;
            if ($urandom_range(0, 3) == 0) i = ~i;
            if ($urandom_range(0, 15) == 0)
                set_cur($urandom_range(1, 12), $urandom_range(0, 59), 1'($urandom_range(0, 1)));
            cyc(m, i);
            act  = {bus.ena, bus.load, bus.load_hh, bus.load_mm, bus.load_pm, bus.setting, bus.blank};
            expv = exp_vec();
            tests++;
            if (act !== expv) begin
                fails++;
                $display("FAIL random c=%0d: got %h want %h", c, act, expv);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.btn_mode = 1'b0;
        bus.btn_inc  = 1'b0;
        set_cur(12, 0, 1'b0);
        #1 reset = 1'b0;
        test_reset();
        test_set_sequence();
        test_hour_wrap();
        test_simultaneous();
        test_reset_mid_set();
        test_inc_hold();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/clock_set_ctrl.md
# clock_set_ctrl

Sequencing controller for `clock_main`: generates its 1 Hz `ena` tick from the board clock and runs the two-button time-set sequence (mode/increment). The block snapshots the running time into edit registers, steps hours and minutes in BCD, and hands the result back through a one-cycle load strobe. It sits between the debounced push-button inputs and `clock_main`, and drives the display blink mask.

## Interface
- `TICK_DIV`, 100_000_000: clk cycles per `ena` pulse; must be ≥ 4.
- `REPEAT_DLY`, 50_000_000: cycles `btn_inc` is held before auto-repeat starts (macro builds only).
- `REPEAT_PER`, 20_000_000: cycles between auto-repeat steps (macro builds only).

- `clk` in 1: system clock; all logic on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `btn_mode` in 1: debounced, synchronous level; the block acts on its rising edge.
- `btn_inc` in 1: debounced, synchronous level; the block acts on its rising edge.
- `cur_hh` in 8: running hours from `clock_main`, BCD 01–12.
- `cur_mm` in 8: running minutes, BCD 00–59.
- `cur_pm` in 1: running PM flag.
- `ena` out 1: one-cycle tick to `clock_main`.
- `load` out 1: one-cycle strobe; `clock_main` takes `load_hh`/`load_mm`/`load_pm` and clears seconds to 00.
- `load_hh` out 8: edit hours, BCD.
- `load_mm` out 8: edit minutes, BCD.
- `load_pm` out 1: edit PM flag.
- `setting` out 1: high in any set state.
- `blank` out 2: [1] blank hours digits, [0] blank minutes digits.

## Operation
- States: RUN, SET_HH, SET_MM.
- Reset values: state RUN, prescaler 0, `ena` 0, `load` 0, `load_hh` 8'h12, `load_mm` 8'h00, `load_pm` 0, `setting` 0, `blank` 2'b00.
- RUN:
  - The prescaler counts 0..TICK_DIV-1; `ena` = 1 in the cycle the count wraps to 0.
  - Mode edge → SET_HH; the edit registers capture `cur_hh`/`cur_mm`/`cur_pm` on that edge.
  - Inc edges are ignored.
- SET_HH:
  - `ena` is held 0 and the prescaler keeps free-running for blink.
  - Inc edge steps hours: 01→…→11→12 toggles `load_pm`; 12→01 leaves `load_pm` unchanged. Other values use a BCD +1 with a units 9→0 carry.
  - Mode edge → SET_MM.
- SET_MM:
  - Inc edge steps minutes 00..59, 59→00, with no carry into hours.
  - Mode edge → RUN: `load` = 1 for exactly one cycle (the first cycle in RUN) and the prescaler is zeroed.
- Blink: `blink` = (prescaler < TICK_DIV/2). `blank` = {SET_HH & ~blink, SET_MM & ~blink}.
- Mode and inc edges in the same cycle: mode wins and the inc is discarded.
- Edge detectors reset to 1, so a button held through reset release does not generate an edge.
- `setting` is a registered decode of the state.

## Timing
- Button edge to state/edit-register change: 1 cycle. Edges are detected against a registered copy of the input.
- `load` is asserted in the cycle after the mode edge in SET_MM.
- First `ena` after `load`: exactly TICK_DIV cycles after the `load` cycle.
- `ena` and `load` are never high in the same cycle.
- Reset asserted mid-set: immediate return to RUN, with no `load` issued.

## Configuration
- `CLOCK_SET_AUTOREPEAT_EN` defined:
  - In SET_HH/SET_MM, an inc held continuously for REPEAT_DLY cycles after its edge produces a step, then another every REPEAT_PER cycles until release.
  - The repeat counter clears on release and on any state change.
- Not defined: one step per rising edge only; the repeat counter and its parameters are not instantiated.

## Structure
- Package `clock_pkg`: state enum (RUN/SET_HH/SET_MM), BCD constants (HH_MIN 8'h01, HH_MAX 8'h12, MM_MAX 8'h59), and functions `bcd_inc_hh` (returns next hours plus pm-toggle flag) and `bcd_inc_mm`.
- Sub-module `clock_tick_gen`: prescaler producing `ena`, `blink` and a synchronous `clr` input; instantiated once.

## Test plan
- TICK_DIV=10, idle after reset → `ena` pulses at cycles 10, 20, 30 after reset release; `load` stays 0.
- Running 11:58 AM; mode, inc, mode, inc, inc, mode → `load`=1 with `load_hh`=8'h12, `load_mm`=8'h00, `load_pm`=1; `ena` absent in set states, next `ena` 10 cycles after `load`.
- SET_HH at 8'h12, inc → 8'h01 with pm unchanged; from 8'h09, inc → 8'h10.
- Mode and inc rising in the same cycle in SET_HH → state SET_MM, hours unchanged.
- Reset pulled low in SET_MM → all outputs at reset values, state RUN, no `load`.
- With the macro, REPEAT_DLY=20 and REPEAT_PER=5, inc held 35 cycles in SET_MM from 8'h57 → `load_mm` steps to 58, 59, 00, 01 (edge, +20, +25, +30).
